fixed_subframe_encoder: RTL and testbench
=========================================

FIXED_SUBFRAME_ENCODER -- requirements
Module: fixed_subframe_encoder

Interface
REQ-001 SHALL have parameter BPS, default 16, input sample width in bits; only 16 is required to be supported.
REQ-002 SHALL have port iClock, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port iReset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port iEnable, input, 1, global enable; when low, all state, counters and outputs hold.
REQ-005 SHALL have port iStart, input, 1, frame start pulse, sampled only in IDLE.
REQ-006 SHALL have port iNSamples, input, 16, block size, latched on start.
REQ-007 SHALL have port iOrder, input, 3, fixed predictor order, latched on start.
REQ-008 SHALL have port iRiceParam, input, 4, Rice parameter k, latched on start.
REQ-009 SHALL have port iStartAddr, input, 16, first RAM word address, latched on start.
REQ-010 SHALL have ports iSample, input, 16 signed, and iSampleValid, input, 1, the sample stream.
REQ-011 SHALL have port oSampleReady, output, 1; a sample transfers on a cycle where iSampleValid and oSampleReady are both high.
REQ-012 SHALL have ports oWriteData, output, 16; oWriteAddr, output, 16; oWriteEnable, output, 1; these form the RAM write port.
REQ-013 SHALL have ports oBusy, output, 1; oFrameDone, output, 1; oError, output, 1.

Function
REQ-014 SHALL use states IDLE, HEADER, WARMUP, PARAMS, RESID_WAIT, UNARY, BINARY, FLUSH and DONE.
REQ-015 In IDLE with iStart high and iOrder<=4, iRiceParam<=14 and iNSamples>iOrder, SHALL latch all inputs and go to HEADER; oBusy is high in every state except IDLE.
REQ-016 In IDLE with iStart high and any of the REQ-015 conditions violated, SHALL pulse oError for 1 cycle, stay in IDLE and perform no writes.
REQ-017 SHALL emit exactly one stream bit per enabled cycle in HEADER, WARMUP (after sample accept), PARAMS, UNARY, BINARY and FLUSH, MSB-first.
REQ-018 HEADER SHALL emit 8 bits: 0, then 001 followed by order[2:0], then 0 (wasted-bits flag).
REQ-019 WARMUP SHALL, iOrder times, assert oSampleReady, accept a sample and emit its 16 bits verbatim; oSampleReady is low while bits are being emitted.
REQ-020 PARAMS SHALL emit 10 bits: 00 (method), 0000 (partition order), then k[3:0].
REQ-021 RESID_WAIT SHALL assert oSampleReady, and on transfer compute residual r in 21-bit signed using history s1..s4 (most recent first):
- order 0: r = s
- order 1: r = s - s1
- order 2: r = s - 2s1 + s2
- order 3: r = s - 3s1 + 3s2 - s3
- order 4: r = s - 4s1 + 6s2 - 4s3 + s4
REQ-022 SHALL update the history with every accepted sample, warm-up and residual alike.
REQ-023 SHALL map the residual to u (22-bit unsigned): u = 2r when r>=0, and u = -2r-1 otherwise.
REQ-024 UNARY SHALL emit q = u>>k zero bits followed by a single 1; BINARY SHALL emit u[k-1:0] MSB-first, and is skipped when k=0.
REQ-025 After BINARY, SHALL return to RESID_WAIT until iNSamples-iOrder residuals have been encoded, then go to FLUSH.
REQ-026 FLUSH SHALL emit 0 bits until the word is full; if the word is already empty on entry, FLUSH SHALL emit nothing.
REQ-027 When the 16th bit of a word is emitted, the next cycle SHALL present oWriteData=word and oWriteEnable=1 for 1 cycle, with oWriteAddr = iStartAddr + word index; addresses wrap modulo 2^16.
REQ-028 After the final write, SHALL enter DONE, pulse oFrameDone for 1 cycle, then return to IDLE; oWriteAddr holds its last value.
REQ-029 A stall (iSampleValid low) SHALL emit no bits and leave the partial word intact.

Reset
REQ-030 On reset, oSampleReady, oWriteEnable, oFrameDone, oError and oBusy SHALL be 0; oWriteData and oWriteAddr SHALL be 0x0000; the history and bit counters SHALL be cleared; state SHALL be IDLE.
REQ-031 Reset mid-frame SHALL take effect on the next edge regardless of iEnable, discard the partial word, and issue no further writes.

Verification
REQ-032 Order 0, k=0, N=1, addr 0x0040, sample 0 -> writes 0x1000@0x0040, 0x2000@0x0041, then oFrameDone.
REQ-033 Order 1, k=2, N=2, samples 100, 98 -> writes 0x1200, 0x6400, 0xB800 at consecutive addresses.
REQ-034 Order 2, 4 samples, iSampleValid held low 5 cycles before each sample -> output words identical to the unstalled run; no bits emitted during the stalls.
REQ-035 iStart with iOrder=5 (or k=15, or N=iOrder) -> 1-cycle oError, oBusy stays 0, no writes.
REQ-036 iReset asserted during UNARY -> all outputs 0 next cycle, no further writes; a following valid frame encodes correctly.
REQ-037 iEnable low for 3 cycles mid-frame -> outputs frozen; final word stream unchanged.

Source files
------------

// File: rtl/fixed_subframe_encoder.sv
// FLAC FIXED subframe encoder: header, verbatim warm-up samples and Rice-coded
// residuals, packed MSB-first into 16-bit words written to a RAM port.
module fixed_subframe_encoder #(
    parameter int BPS = 16
) (
    input  logic                  iClock,
    input  logic                  iReset,
    input  logic                  iEnable,
    input  logic                  iStart,
    input  logic [15:0]           iNSamples,
    input  logic [2:0]            iOrder,
    input  logic [3:0]            iRiceParam,
    input  logic [15:0]           iStartAddr,
    input  logic signed [BPS-1:0] iSample,
    input  logic                  iSampleValid,
    output logic                  oSampleReady,
    output logic [15:0]           oWriteData,
    output logic [15:0]           oWriteAddr,
    output logic                  oWriteEnable,
    output logic                  oBusy,
    output logic                  oFrameDone,
    output logic                  oError
);
    typedef enum logic [3:0] {
        IDLE, HEADER, WARMUP, PARAMS, RESID_WAIT, UNARY, BINARY, FLUSH, DONE
    } state_t;
    localparam int SW = 22;

    state_t              state_q, state_d;
    logic [SW-1:0]       sh_q, q_q;
    logic [4:0]          cnt_q;
    logic [2:0]          order_q, warm_q;
    logic [3:0]          k_q, bitcnt_q;
    logic [15:0]         res_q, base_q, widx_q, word_q, wdata_q, waddr_q;
    logic signed [BPS-1:0] s1_q, s2_q, s3_q, s4_q;
    logic                we_q, err_q;

    logic                cfg_ok, rdy, xfer, emit, ebit;
    logic signed [20:0]  xs, x1, x2, x3, x4, r;
    logic [SW-1:0]       r2, u, hdr, prm;

    assign cfg_ok = (iOrder <= 3'd4) && (iRiceParam <= 4'd14) && (iNSamples > {13'd0, iOrder});
    assign xfer   = oSampleReady && iSampleValid;

    // Fixed-predictor residual over sign-extended history, then zigzag fold.
    assign xs = {{(21-BPS){iSample[BPS-1]}}, iSample};
    assign x1 = {{(21-BPS){s1_q[BPS-1]}}, s1_q};
    assign x2 = {{(21-BPS){s2_q[BPS-1]}}, s2_q};
    assign x3 = {{(21-BPS){s3_q[BPS-1]}}, s3_q};
    assign x4 = {{(21-BPS){s4_q[BPS-1]}}, s4_q};
    always_comb begin
        case (order_q)
            3'd1:    r = xs - x1;
            3'd2:    r = xs - (x1 <<< 1) + x2;
            3'd3:    r = xs - (x1 <<< 1) - x1 + (x2 <<< 1) + x2 - x3;
            3'd4:    r = xs - (x1 <<< 2) + (x2 <<< 2) + (x2 <<< 1) - (x3 <<< 2) + x4;
            default: r = xs;
        endcase
    end
    assign r2  = {r, 1'b0};
    assign u   = r[20] ? ~r2 : r2;
    assign hdr = {1'b0, 3'b001, iOrder, 1'b0, 14'd0};
    assign prm = {6'd0, k_q, 12'd0};

    always_ff @(posedge iClock) begin
        if (iReset) state_q <= IDLE;
        else if (iEnable) state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (iStart && cfg_ok) state_d = HEADER;
            HEADER:     if (cnt_q == 5'd1) state_d = (order_q == 3'd0) ? PARAMS : WARMUP;
            WARMUP:     if (cnt_q == 5'd1 && warm_q == 3'd0) state_d = PARAMS;
            PARAMS:     if (cnt_q == 5'd1) state_d = RESID_WAIT;
            RESID_WAIT: if (xfer) state_d = UNARY;
            UNARY:      if (q_q == '0) begin
                            if (k_q != 4'd0) state_d = BINARY;
                            else state_d = (res_q == 16'd0) ? FLUSH : RESID_WAIT;
                        end
            BINARY:     if (cnt_q == 5'd1) state_d = (res_q == 16'd0) ? FLUSH : RESID_WAIT;
            FLUSH:      if (bitcnt_q == 4'd0) state_d = DONE;
            DONE:       state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        rdy  = 1'b0;
        emit = 1'b0;
        ebit = sh_q[SW-1];
        case (state_q)
            HEADER, PARAMS, BINARY: emit = 1'b1;
            WARMUP:     if (cnt_q == 5'd0) rdy = 1'b1; else emit = 1'b1;
            RESID_WAIT: rdy = 1'b1;
            UNARY:      begin emit = 1'b1; ebit = (q_q == '0); end
            FLUSH:      begin emit = (bitcnt_q != 4'd0); ebit = 1'b0; end
            default:    ;
        endcase
        oSampleReady = rdy && iEnable;
        oBusy        = (state_q != IDLE);
        oFrameDone   = (state_q == DONE);
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            sh_q <= '0; q_q <= '0; cnt_q <= '0; order_q <= '0; warm_q <= '0;
            k_q <= '0; bitcnt_q <= '0; res_q <= '0; base_q <= '0; widx_q <= '0;
            word_q <= '0; wdata_q <= '0; waddr_q <= '0; we_q <= 1'b0; err_q <= 1'b0;
            s1_q <= '0; s2_q <= '0; s3_q <= '0; s4_q <= '0;
        end else if (iEnable) begin
            err_q <= (state_q == IDLE) && iStart && !cfg_ok;
            we_q  <= 1'b0;
            if (emit) begin
                word_q   <= {word_q[14:0], ebit};
                bitcnt_q <= bitcnt_q + 4'd1;
                if (bitcnt_q == 4'd15) begin
                    wdata_q <= {word_q[14:0], ebit};
                    waddr_q <= base_q + widx_q;
                    widx_q  <= widx_q + 16'd1;
                    we_q    <= 1'b1;
                end
            end
            if (xfer) begin
                s4_q <= s3_q; s3_q <= s2_q; s2_q <= s1_q; s1_q <= iSample;
            end
            case (state_q)
                IDLE: if (iStart && cfg_ok) begin
                    order_q <= iOrder; warm_q <= iOrder; k_q <= iRiceParam;
                    base_q  <= iStartAddr; widx_q <= 16'd0;
                    res_q   <= iNSamples - {13'd0, iOrder};
                    sh_q    <= hdr; cnt_q <= 5'd8;
                end
                HEADER: begin
                    sh_q <= sh_q << 1; cnt_q <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1 && order_q == 3'd0) begin sh_q <= prm; cnt_q <= 5'd10; end
                end
                WARMUP: if (cnt_q == 5'd0) begin
                    if (xfer) begin
                        sh_q <= {iSample, {(SW-BPS){1'b0}}}; cnt_q <= 5'(BPS); warm_q <= warm_q - 3'd1;
                    end
                end else begin
                    sh_q <= sh_q << 1; cnt_q <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1 && warm_q == 3'd0) begin sh_q <= prm; cnt_q <= 5'd10; end
                end
                PARAMS, BINARY: begin sh_q <= sh_q << 1; cnt_q <= cnt_q - 5'd1; end
                RESID_WAIT: if (xfer) begin
                    q_q   <= u >> k_q;
                    sh_q  <= u << (5'd22 - {1'b0, k_q});
                    cnt_q <= {1'b0, k_q};
                    res_q <= res_q - 16'd1;
                end
                UNARY: if (q_q != '0) q_q <= q_q - 1'b1;
                default: ;
            endcase
        end
    end

    assign oWriteData   = wdata_q;
    assign oWriteAddr   = waddr_q;
    assign oWriteEnable = we_q;
    assign oError       = err_q;
endmodule

// File: tb/tb_fixed_subframe_encoder.sv
// Scoreboard bench: expected RAM writes are queued from a bit-level FLAC model
// (or known vectors) when a frame is launched and popped as the DUT writes.
module tb_fixed_subframe_encoder;
    logic        iClock = 1'b0, iReset, iEnable, iStart, iSampleValid;
    logic [15:0] iNSamples, iStartAddr, iSample;
    logic [2:0]  iOrder;
    logic [3:0]  iRiceParam;
    logic        oSampleReady, oWriteEnable, oBusy, oFrameDone, oError;
    logic [15:0] oWriteData, oWriteAddr;

    int          n_chk = 0, n_pass = 0;
    logic [31:0] exp_q[$];
    int          smp[$];

    fixed_subframe_encoder #(.BPS(16)) dut (
        .iClock(iClock), .iReset(iReset), .iEnable(iEnable), .iStart(iStart),
        .iNSamples(iNSamples), .iOrder(iOrder), .iRiceParam(iRiceParam),
        .iStartAddr(iStartAddr), .iSample(iSample), .iSampleValid(iSampleValid),
        .oSampleReady(oSampleReady), .oWriteData(oWriteData), .oWriteAddr(oWriteAddr),
        .oWriteEnable(oWriteEnable), .oBusy(oBusy), .oFrameDone(oFrameDone), .oError(oError)
    );

    always #5 iClock = ~iClock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    endtask

    // A write lands on an enabled edge; a frozen repeat under iEnable=0 is not a new write.
    always @(negedge iClock) begin
        if (!iReset && iEnable && oWriteEnable) begin
            chk("write_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("write", {oWriteAddr, oWriteData}, exp_q.pop_front());
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    // Bit-serial reference encoder over smp[0..n-1].
    task automatic model(input int order, input int k, input logic [15:0] addr);
        bit bits[$];
        int r, u;
        logic [15:0] w, a;
        bits = {1'b0, 1'b0, 1'b0, 1'b1, bit'(order >> 2), bit'(order >> 1), bit'(order), 1'b0};
        for (int i = 0; i < order; i++)
            for (int b = 15; b >= 0; b--) bits.push_back(bit'(smp[i] >> b));
        for (int b = 0; b < 6; b++) bits.push_back(1'b0);
        for (int b = 3; b >= 0; b--) bits.push_back(bit'(k >> b));
        for (int i = order; i < smp.size(); i++) begin
            case (order)
                1: r = smp[i] - smp[i-1];
                2: r = smp[i] - 2*smp[i-1] + smp[i-2];
                3: r = smp[i] - 3*smp[i-1] + 3*smp[i-2] - smp[i-3];
                4: r = smp[i] - 4*smp[i-1] + 6*smp[i-2] - 4*smp[i-3] + smp[i-4];
                default: r = smp[i];
            endcase
            u = (r >= 0) ? 2*r : -2*r - 1;
            for (int z = 0; z < (u >> k); z++) bits.push_back(1'b0);
            bits.push_back(1'b1);
            for (int b = k - 1; b >= 0; b--) bits.push_back(bit'(u >> b));
        end
        while (bits.size() % 16 != 0) bits.push_back(1'b0);
        for (int wi = 0; wi < bits.size() / 16; wi++) begin
            for (int b = 0; b < 16; b++) w[15-b] = bits[wi*16 + b];
            a = addr + 16'(wi);
            exp_q.push_back({a, w});
        end
    endtask

    task automatic start_frame(input int order, input int k, input int n, input logic [15:0] addr);
        @(posedge iClock); #1;
        iOrder = 3'(order); iRiceParam = 4'(k); iNSamples = 16'(n); iStartAddr = addr; iStart = 1'b1;
        @(posedge iClock); #1;
        iStart = 1'b0;
    endtask

    task automatic send(input int s, input int stall, output bit ok);
        int cyc = 0;
        ok = 1'b0;
        iSampleValid = 1'b0;
        if (stall > 0) begin repeat (stall) @(posedge iClock); #1; end
        iSample = 16'(s);
        iSampleValid = 1'b1;
        while (!ok && cyc < 2000) begin
            @(negedge iClock);
            ok = oSampleReady;
            cyc++;
            @(posedge iClock); #1;
        end
        iSampleValid = 1'b0;
        if (!ok) chk("sample_ready", ok, 1);
    endtask

    task automatic run_frame(input int order, input int k, input int n, input logic [15:0] addr, input int stall);
        bit ok;
        int cyc = 0;
        start_frame(order, k, n, addr);
        for (int i = 0; i < n; i++) begin
            send(smp[i], stall, ok);
            if (!ok) return;
        end
        while (!oFrameDone && cyc < 3000) begin @(negedge iClock); cyc++; end
        chk("frame_done", oFrameDone, 1);
        chk("all_words", exp_q.size(), 0);
    endtask

    task automatic bad_start(input int order, input int k, input int n, input string tag);
        start_frame(order, k, n, 16'h0300);
        @(negedge iClock);
        chk({tag, "_err"}, oError, 1);
        chk({tag, "_busy"}, oBusy, 0);
        @(negedge iClock);
        chk({tag, "_err_clr"}, oError, 0);
    endtask

    task automatic glitch();
        logic [33:0] snap;
        repeat (30) @(posedge iClock);
        #2 iEnable = 1'b0;
        @(negedge iClock);
        snap = {oWriteData, oWriteAddr, oWriteEnable, oBusy};
        for (int i = 0; i < 3; i++) begin
            @(posedge iClock);
            if (i == 2) #2 iEnable = 1'b1;
            @(negedge iClock);
            chk("en_freeze", {oWriteData, oWriteAddr, oWriteEnable, oBusy}, snap);
        end
    endtask

    task automatic push_req033(input logic [15:0] a);
        exp_q.push_back({a, 16'h1200});
        exp_q.push_back({a + 16'd1, 16'h6400});
        exp_q.push_back({a + 16'd2, 16'hB800});
    endtask

    initial begin
        bit ok;
        iReset = 1'b1; iEnable = 1'b1; iStart = 1'b0; iSampleValid = 1'b0; iSample = '0;
        iNSamples = '0; iOrder = '0; iRiceParam = '0; iStartAddr = '0;
        repeat (3) @(posedge iClock);
        @(negedge iClock);
        chk("rst_ctrl", {oSampleReady, oWriteEnable, oFrameDone, oError, oBusy}, 0);
        chk("rst_data", oWriteData, 0);
        chk("rst_addr", oWriteAddr, 0);
        @(posedge iClock); #1 iReset = 1'b0;

        smp = {0};
        exp_q.push_back({16'h0040, 16'h1000});
        exp_q.push_back({16'h0041, 16'h2000});
        run_frame(0, 0, 1, 16'h0040, 0);

        smp = {100, 98};
        push_req033(16'h0100);
        run_frame(1, 2, 2, 16'h0100, 0);

        smp = {1000, -500, 300, 7};
        model(2, 3, 16'h0200);
        run_frame(2, 3, 4, 16'h0200, 0);
        model(2, 3, 16'h0200);
        run_frame(2, 3, 4, 16'h0200, 5);

        bad_start(5, 2, 10, "order5");
        bad_start(1, 15, 10, "k15");
        bad_start(2, 2, 2, "n_eq_order");

        smp = {};
        for (int i = 0; i < 24; i++) smp.push_back(int'($signed(16'($urandom))));
        model(4, 14, 16'hFFFE);
        run_frame(4, 14, 24, 16'hFFFE, 0);

        smp = {};
        for (int i = 0; i < 8; i++) smp.push_back(int'($urandom_range(6)) - 3);
        model(3, 0, 16'h0500);
        run_frame(3, 0, 8, 16'h0500, 0);

        // Reset while a long unary run is in progress, with iEnable low.
        exp_q.push_back({16'h0600, 16'h1000});
        start_frame(0, 0, 1, 16'h0600);
        send(100, 0, ok);
        repeat (3) @(posedge iClock);
        #1 iReset = 1'b1; iEnable = 1'b0;
        @(posedge iClock);
        @(negedge iClock);
        chk("midrst_ctrl", {oSampleReady, oWriteEnable, oFrameDone, oError, oBusy}, 0);
        chk("midrst_data", {oWriteData, oWriteAddr}, 0);
        #1 iReset = 1'b0; iEnable = 1'b1;
        repeat (30) @(negedge iClock);
        chk("midrst_words", exp_q.size(), 0);
        chk("midrst_idle", oBusy, 0);
        smp = {100, 98};
        push_req033(16'h0700);
        run_frame(1, 2, 2, 16'h0700, 0);

        smp = {};
        for (int i = 0; i < 10; i++) smp.push_back(int'($urandom_range(400)) - 200);
        model(1, 3, 16'h0800);
        fork
            run_frame(1, 3, 10, 16'h0800, 0);
            glitch();
        join

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
